// File: rtl/pe_mac_acc_pkg.sv
// Shared types and signed-range helpers for the systolic MAC processing element.
// The min/max helpers are reused by the array controller for its own clamping.
package pe_mac_acc_pkg;

    localparam int PE_DATA_WIDTH = 8;
    localparam int PE_ACC_WIDTH  = 32;
    localparam int PE_LANES      = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } pe_acc_state_t;

    function automatic logic signed [63:0] acc_max(input int width);
        logic signed [63:0] one;
        one = 64'sd1;
        return (one <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] acc_min(input int width);
        return ~acc_max(width);
    endfunction

    function automatic logic signed [63:0] sat_acc(input logic signed [63:0] value, input int width);
        logic signed [63:0] res;
        if (value > acc_max(width)) begin
            res = acc_max(width);
        end else if (value < acc_min(width)) begin
            res = acc_min(width);
        end else begin
            res = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_mac_acc_if.sv
// Beat input, neighbour forwarding and result handshake of one processing element.
interface pe_mac_acc_if
    import pe_mac_acc_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int LANES      = PE_LANES,
    parameter int ACC_WIDTH  = PE_ACC_WIDTH
);
    logic                          in_valid;
    logic                          in_ready;
    logic [LANES*DATA_WIDTH-1:0]   in_a;
    logic [LANES*DATA_WIDTH-1:0]   in_b;
    logic                          in_first;
    logic                          in_last;
    logic [LANES*DATA_WIDTH-1:0]   fwd_a;
    logic [LANES*DATA_WIDTH-1:0]   fwd_b;
    logic                          fwd_valid;
    logic [ACC_WIDTH-1:0]          out_d;
    logic                          out_ovf;
    logic                          out_valid;
    logic                          out_ready;

    modport master (
        output in_valid, in_a, in_b, in_first, in_last, out_ready,
        input  in_ready, fwd_a, fwd_b, fwd_valid, out_d, out_ovf, out_valid
    );

    modport slave (
        input  in_valid, in_a, in_b, in_first, in_last, out_ready,
        output in_ready, fwd_a, fwd_b, fwd_valid, out_d, out_ovf, out_valid
    );

endinterface

// File: rtl/pe_mac_acc_dot_lanes.sv
// Combinational signed dot product of LANES a/b element pairs, sign-extended to SUM_WIDTH.
module pe_mac_acc_dot_lanes #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int SUM_WIDTH  = 33
) (
    input  logic [LANES*DATA_WIDTH-1:0] i_a,
    input  logic [LANES*DATA_WIDTH-1:0] i_b,
    output logic signed [SUM_WIDTH-1:0] o_sum
);
    localparam int PROD_W = 2 * DATA_WIDTH;

    logic signed [PROD_W-1:0]    w_prod;
    logic signed [SUM_WIDTH-1:0] w_acc;

    // Multiply each lane pair and accumulate; synthesis balances the chain into a tree.
    always_comb begin
        w_acc  = '0;
        w_prod = '0;
        for (int i = 0; i < LANES; i++) begin
            w_prod = $signed(i_a[i*DATA_WIDTH +: DATA_WIDTH]) * $signed(i_b[i*DATA_WIDTH +: DATA_WIDTH]);
            w_acc  = w_acc + {{(SUM_WIDTH-PROD_W){w_prod[PROD_W-1]}}, w_prod};
        end
    end

    assign o_sum = w_acc;

endmodule

// File: rtl/pe_mac_acc.sv
// Output-stationary systolic MAC cell: multi-lane dot product into a local accumulator,
// a/b forwarded to neighbours one cycle later, tagged result on a valid/ready slot.
module pe_mac_acc
    import pe_mac_acc_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int ACC_WIDTH  = PE_ACC_WIDTH,
    parameter int LANES      = PE_LANES,
    parameter int SATURATE   = 1
) (
    input  logic        clk,
    input  logic        rst,
    pe_mac_acc_if.slave bus
);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int TREE_W = PROD_W + $clog2(LANES);
    // The lane sum never wraps, even when ACC_WIDTH is narrower than the product tree.
    localparam int SUM_W  = ((TREE_W > ACC_WIDTH) ? TREE_W : ACC_WIDTH) + 1;
    localparam int NXT_W  = SUM_W + 1;

    pe_acc_state_t                r_state;
    pe_acc_state_t                w_state_nxt;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic                         r_ovf_acc;
    logic signed [ACC_WIDTH-1:0]  r_out_d;
    logic                         r_out_ovf;
    logic                         r_out_valid;
    logic [LANES*DATA_WIDTH-1:0]  r_fwd_a;
    logic [LANES*DATA_WIDTH-1:0]  r_fwd_b;
    logic                         r_fwd_valid;

    logic                         w_in_ready;
    logic                         w_accept;
    logic                         w_restart;
    logic                         w_acc_load;
    logic                         w_res_load;
    logic signed [SUM_W-1:0]      w_sum;
    logic signed [NXT_W-1:0]      w_base;
    logic signed [NXT_W-1:0]      w_nxt;
    logic signed [63:0]           w_nxt64;
    logic                         w_ovf_now;
    logic                         w_ovf_tot;
    logic signed [ACC_WIDTH-1:0]  w_res;

    pe_mac_acc_dot_lanes #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .SUM_WIDTH  (SUM_W)
    ) u_dot (
        .i_a   (bus.in_a),
        .i_b   (bus.in_b),
        .o_sum (w_sum)
    );

    assign w_in_ready = ~r_out_valid | bus.out_ready;
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_restart  = bus.in_first | (r_state == IDLE);

    // Next accumulator value, range check and clamp/wrap of the result.
    always_comb begin
        if (w_restart) begin
            w_base = '0;
        end else begin
            w_base = {{(NXT_W-ACC_WIDTH){r_acc[ACC_WIDTH-1]}}, r_acc};
        end
        w_nxt     = w_base + {{(NXT_W-SUM_W){w_sum[SUM_W-1]}}, w_sum};
        w_nxt64   = {{(64-NXT_W){w_nxt[NXT_W-1]}}, w_nxt};
        w_ovf_now = (w_nxt64 > acc_max(ACC_WIDTH)) || (w_nxt64 < acc_min(ACC_WIDTH));
        w_ovf_tot = w_ovf_now | (~w_restart & r_ovf_acc);
        if (SATURATE != 0) begin
            w_res = ACC_WIDTH'(sat_acc(w_nxt64, ACC_WIDTH));
        end else begin
            w_res = ACC_WIDTH'(w_nxt64);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: any accepted last beat closes the accumulation.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !bus.in_last) begin
                    w_state_nxt = ACC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACC: begin
                if (w_accept && bus.in_last) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = ACC;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: which register set an accepted beat updates.
    always_comb begin
        w_acc_load = 1'b0;
        w_res_load = 1'b0;
        case (r_state)
            IDLE, ACC: begin
                w_acc_load = w_accept & ~bus.in_last;
                w_res_load = w_accept &  bus.in_last;
            end
            default: begin
                w_acc_load = 1'b0;
                w_res_load = 1'b0;
            end
        endcase
    end

    // Accumulator, sticky overflow and result slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_ovf_acc   <= 1'b0;
            r_out_d     <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_res_load) begin
                r_acc       <= '0;
                r_ovf_acc   <= 1'b0;
                r_out_d     <= w_res;
                r_out_ovf   <= w_ovf_tot;
                r_out_valid <= 1'b1;
            end else begin
                if (w_acc_load) begin
                    r_acc     <= w_res;
                    r_ovf_acc <= w_ovf_tot;
                end
                if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    // Neighbour forwarding; a stalled cell forwards nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fwd_a     <= '0;
            r_fwd_b     <= '0;
            r_fwd_valid <= 1'b0;
        end else begin
            r_fwd_valid <= w_accept;
            if (w_accept) begin
                r_fwd_a <= bus.in_a;
                r_fwd_b <= bus.in_b;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_d     = r_out_d;
    assign bus.out_ovf   = r_out_ovf;
    assign bus.out_valid = r_out_valid;
    assign bus.fwd_a     = r_fwd_a;
    assign bus.fwd_b     = r_fwd_b;
    assign bus.fwd_valid = r_fwd_valid;

endmodule

// File: tb/tb_pe_mac_acc.sv
// Self-checking bench for pe_mac_acc: directed scenarios plus randomized traffic
// compared against a transaction-level arithmetic reference model.
module tb_pe_mac_acc;

    localparam longint MAX32 = 64'sd2147483647;
    localparam longint MIN32 = -64'sd2147483648;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    pe_mac_acc_if #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(32)) bus ();
    pe_mac_acc_if #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(16)) bus16s ();
    pe_mac_acc_if #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(16)) bus16w ();

    pe_mac_acc #(.DATA_WIDTH(8), .ACC_WIDTH(32), .LANES(4), .SATURATE(1)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    pe_mac_acc #(.DATA_WIDTH(8), .ACC_WIDTH(16), .LANES(4), .SATURATE(1)) dut16s (
        .clk (clk), .rst (rst), .bus (bus16s)
    );
    pe_mac_acc #(.DATA_WIDTH(8), .ACC_WIDTH(16), .LANES(4), .SATURATE(0)) dut16w (
        .clk (clk), .rst (rst), .bus (bus16w)
    );

    always #5 clk = ~clk;

    // Reference model state (main 32-bit saturating cell).
    longint      m_acc;
    bit          m_active;
    bit          m_ovf;
    logic [31:0] m_out_d;
    bit          m_out_ovf;
    bit          m_out_valid;
    logic [31:0] m_fwd_a;
    logic [31:0] m_fwd_b;
    bit          m_fwd_valid;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input byte l0, input byte l1, input byte l2, input byte l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic longint dot(input logic [31:0] a, input logic [31:0] b);
        longint s;
        byte    x;
        byte    y;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            x = a[i*8 +: 8];
            y = b[i*8 +: 8];
            s += longint'(x) * longint'(y);
        end
        return s;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_active = 0; m_ovf = 0;
        m_out_d = '0; m_out_ovf = 0; m_out_valid = 0;
        m_fwd_a = '0; m_fwd_b = '0; m_fwd_valid = 0;
    endtask

    task automatic model_step(input bit acc, input logic [31:0] a, input logic [31:0] b,
                              input bit first, input bit last, input bit ordy);
        longint n;
        longint c;
        bit     fresh;
        bit     o;
        bit     sticky;
        if (acc) begin
            fresh  = first || !m_active;
            n      = (fresh ? 64'sd0 : m_acc) + dot(a, b);
            o      = (n > MAX32) || (n < MIN32);
            c      = (n > MAX32) ? MAX32 : ((n < MIN32) ? MIN32 : n);
            sticky = o || (!fresh && m_ovf);
            if (last) begin
                m_out_d = c[31:0]; m_out_ovf = sticky;
                m_acc = 0; m_active = 0; m_ovf = 0;
            end else begin
                m_acc = c; m_ovf = sticky; m_active = 1;
            end
            m_fwd_a = a; m_fwd_b = b;
        end
        if (acc && last) m_out_valid = 1;
        else if (ordy)   m_out_valid = 0;
        m_fwd_valid = acc;
    endtask

    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b, input bit f, input bit l);
        bus.in_valid = v; bus.in_a = a; bus.in_b = b; bus.in_first = f; bus.in_last = l;
    endtask

    task automatic drive16(input bit v, input logic [31:0] a, input logic [31:0] b, input bit f, input bit l);
        bus16s.in_valid = v; bus16s.in_a = a; bus16s.in_b = b; bus16s.in_first = f; bus16s.in_last = l;
        bus16w.in_valid = v; bus16w.in_a = a; bus16w.in_b = b; bus16w.in_first = f; bus16w.in_last = l;
    endtask

    // One clock of the main cell: check in_ready, advance model, check registered outputs.
    task automatic tick();
        bit rdy;
        #1;
        rdy = !m_out_valid || bus.out_ready;
        chk("in_ready", bus.in_ready, rdy);
        model_step(bus.in_valid && rdy, bus.in_a, bus.in_b, bus.in_first, bus.in_last, bus.out_ready);
        @(posedge clk);
        #1;
        chk("out_valid", bus.out_valid, m_out_valid);
        chk("out_d", bus.out_d, m_out_d);
        chk("out_ovf", bus.out_ovf, m_out_ovf);
        chk("fwd_valid", bus.fwd_valid, m_fwd_valid);
        chk("fwd_a", bus.fwd_a, m_fwd_a);
        chk("fwd_b", bus.fwd_b, m_fwd_b);
    endtask

    initial begin
        logic [31:0] ones;
        logic [31:0] neg;
        logic [31:0] pos;
        logic [31:0] t6a;
        n_checks = 0;
        n_fail   = 0;
        clk = 1'b0;
        rst = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive16(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        bus.out_ready = 1'b1; bus16s.out_ready = 1'b1; bus16w.out_ready = 1'b1;
        ones = pk(8'sd1, 8'sd1, 8'sd1, 8'sd1);
        neg  = pk(8'sh80, 8'sh80, 8'sh80, 8'sh80);
        pos  = pk(8'sd127, 8'sd127, 8'sd127, 8'sd127);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_out_d", bus.out_d, 64'd0);
        chk("rst_out_valid", bus.out_valid, 64'd0);
        chk("rst_out_ovf", bus.out_ovf, 64'd0);
        chk("rst_fwd_valid", bus.fwd_valid, 64'd0);
        chk("rst_in_ready", bus.in_ready, 64'd1);

        // Single first&last beat
        drive(1'b1, pk(8'sd1, 8'sd2, 8'sd3, 8'sd4), pk(8'sd5, 8'sd6, 8'sd7, 8'sd8), 1'b1, 1'b1);
        tick();
        chk("t1_d", bus.out_d, 64'd70);
        chk("t1_valid", bus.out_valid, 64'd1);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        chk("t1_drop", bus.out_valid, 64'd0);

        // Three beats with a bubble
        drive(1'b1, ones, ones, 1'b1, 1'b0); tick();
        drive(1'b1, ones, ones, 1'b0, 1'b0); tick();
        drive(1'b0, ones, ones, 1'b0, 1'b1); tick();
        chk("t2_no_early", bus.out_valid, 64'd0);
        drive(1'b1, ones, ones, 1'b0, 1'b1); tick();
        chk("t2_d", bus.out_d, 64'd12);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0); tick();

        // Saturate vs wrap on a narrow accumulator
        drive16(1'b1, neg, neg, 1'b1, 1'b0); tick();
        drive16(1'b1, neg, neg, 1'b0, 1'b0); tick();
        drive16(1'b1, neg, neg, 1'b0, 1'b1); tick();
        chk("t3s_d", bus16s.out_d, 64'h7fff);
        chk("t3s_ovf", bus16s.out_ovf, 64'd1);
        chk("t3w_d", bus16w.out_d, 64'd0);
        chk("t3w_ovf", bus16w.out_ovf, 64'd1);
        chk("t3w_valid", bus16w.out_valid, 64'd1);
        drive16(1'b1, neg, neg, 1'b1, 1'b0); tick();
        drive16(1'b1, neg, pos, 1'b0, 1'b1); tick();
        chk("t3s_sticky_d", bus16s.out_d, 64'h81ff);
        chk("t3s_sticky_ovf", bus16s.out_ovf, 64'd1);
        chk("t3w_wrap2_d", bus16w.out_d, 64'h0200);
        chk("t3w_wrap2_ovf", bus16w.out_ovf, 64'd1);
        drive16(1'b1, ones, ones, 1'b1, 1'b1); tick();
        chk("t3s_clear_d", bus16s.out_d, 64'd4);
        chk("t3s_clear_ovf", bus16s.out_ovf, 64'd0);
        chk("t3w_clear_ovf", bus16w.out_ovf, 64'd0);
        drive16(1'b0, 32'd0, 32'd0, 1'b0, 1'b0); tick();

        // Back-pressure and back-to-back results
        drive(1'b1, pk(8'sd1, 8'sd2, 8'sd3, 8'sd4), pk(8'sd5, 8'sd6, 8'sd7, 8'sd8), 1'b1, 1'b1); tick();
        bus.out_ready = 1'b0;
        drive(1'b1, ones, ones, 1'b1, 1'b1); tick();
        chk("t4_hold_d", bus.out_d, 64'd70);
        chk("t4_stall_fwd", bus.fwd_valid, 64'd0);
        chk("t4_in_ready", bus.in_ready, 64'd0);
        tick();
        chk("t4_hold_d2", bus.out_d, 64'd70);
        bus.out_ready = 1'b1;
        tick();
        chk("t4_b2b_d1", bus.out_d, 64'd4);
        chk("t4_b2b_v1", bus.out_valid, 64'd1);
        drive(1'b1, pk(8'sd2, 8'sd0, 8'sd0, 8'sd0), pk(8'sd3, 8'sd0, 8'sd0, 8'sd0), 1'b1, 1'b1); tick();
        chk("t4_b2b_d2", bus.out_d, 64'd6);
        chk("t4_b2b_v2", bus.out_valid, 64'd1);

        // Reset mid-accumulation
        drive(1'b1, ones, ones, 1'b1, 1'b0); tick();
        drive(1'b1, ones, ones, 1'b0, 1'b0); tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("t5_rst_d", bus.out_d, 64'd0);
        chk("t5_rst_valid", bus.out_valid, 64'd0);
        chk("t5_rst_fwd_a", bus.fwd_a, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, pk(8'sd1, 8'sd0, 8'sd0, 8'sd0), pk(8'sd1, 8'sd0, 8'sd0, 8'sd0), 1'b1, 1'b1); tick();
        chk("t5_d", bus.out_d, 64'd1);

        // Restart with in_first in the middle of an accumulation
        t6a = pk(8'sd7, 8'sd0, 8'sd0, 8'sd0);
        drive(1'b1, pk(8'sd5, 8'sd0, 8'sd0, 8'sd0), pk(8'sd10, 8'sd0, 8'sd0, 8'sd0), 1'b1, 1'b0); tick();
        drive(1'b1, t6a, pk(8'sd1, 8'sd0, 8'sd0, 8'sd0), 1'b1, 1'b1); tick();
        chk("t6_d", bus.out_d, 64'd7);
        chk("t6_fwd_a", bus.fwd_a, t6a);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(3) != 0), $urandom(), $urandom(),
                  ($urandom_range(4) == 0), ($urandom_range(3) == 0));
            bus.out_ready = ($urandom_range(3) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
